// File: rtl/stream_packer.sv
// Packs sparse AXI-Stream beats (low-order tkeep bytes) into dense beats; only a packet's last
// beat may be partial. Define STREAM_PACKER_KEEP_CHECK_EN to build the sticky keep_err check.
module stream_packer #(
    parameter int unsigned BYTES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*BYTES-1:0] s_tdata,
    input  logic [BYTES-1:0]   s_tkeep,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic [8*BYTES-1:0] m_tdata,
    output logic [BYTES-1:0]   m_tkeep,
    output logic               m_tvalid,
    output logic               m_tlast,
    input  logic               m_tready,
    output logic               keep_err
);

    localparam int unsigned DataW    = 8 * BYTES;
    localparam int unsigned BufBytes = 2 * BYTES - 1;
    localparam int unsigned BufW     = 8 * BufBytes;
    localparam int unsigned OccW     = $clog2(2 * BYTES) + 1;
    localparam logic [OccW-1:0] FullOcc = OccW'(BYTES);

    logic [BufW-1:0]  buf_q, buf_d;
    logic [OccW-1:0]  occ_q, occ_d;
    logic             flush_q, flush_d;

    logic             s_fire, m_fire;
    logic [OccW-1:0]  occ_drained;
    logic [OccW-1:0]  n_bytes;
    logic [DataW-1:0] in_mask;
    logic [BufW-1:0]  buf_shifted, ins_data, ins_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q   <= '0;
            occ_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            occ_q   <= occ_d;
            flush_q <= flush_d;
        end
    end

    // Output side is driven purely from registers.
    always_comb begin
        m_tvalid = (occ_q >= FullOcc) | flush_q;
        m_tlast  = flush_q & (occ_q <= FullOcc);
        m_tdata  = buf_q[DataW-1:0];
        for (int i = 0; i < BYTES; i++) begin
            m_tkeep[i] = (OccW'(i) < occ_q);
        end
    end

    always_comb begin
        m_fire = m_tvalid & m_tready;
        if (m_fire) begin
            occ_drained = (occ_q >= FullOcc) ? (occ_q - FullOcc) : '0;
        end else begin
            occ_drained = occ_q;
        end
        s_tready = reset & ~flush_q & (occ_drained < FullOcc);
        s_fire   = s_tvalid & s_tready;
    end

    // Byte count is the popcount, so a malformed mask still packs its low-order bytes.
    always_comb begin
        n_bytes = '0;
        for (int i = 0; i < BYTES; i++) begin
            n_bytes = n_bytes + OccW'(s_tkeep[i]);
        end
        in_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            in_mask[8*i +: 8] = {8{OccW'(i) < n_bytes}};
        end
    end

    always_comb begin
        buf_shifted = m_fire ? (buf_q >> DataW) : buf_q;
        ins_data    = BufW'(s_tdata) << {occ_drained, 3'b000};
        ins_mask    = BufW'(in_mask) << {occ_drained, 3'b000};
        buf_d       = buf_shifted;
        occ_d       = occ_drained;
        flush_d     = flush_q;
        if (s_fire) begin
            buf_d = (buf_shifted & ~ins_mask) | (ins_data & ins_mask);
            occ_d = occ_drained + n_bytes;
            if (s_tlast) begin
                flush_d = 1'b1;
            end
        end
        if (m_fire && m_tlast) begin
            occ_d   = '0;
            flush_d = 1'b0;
        end
    end

`ifdef STREAM_PACKER_KEEP_CHECK_EN
    logic           keep_err_q, keep_err_d;
    logic [BYTES:0] keep_ext;

    // A contiguous mask 2^k-1 has no bit in common with itself plus one.
    always_comb begin
        keep_ext   = {1'b0, s_tkeep};
        keep_err_d = keep_err_q |
                     (s_fire & (|(keep_ext & (keep_ext + {{BYTES{1'b0}}, 1'b1}))));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keep_err_q <= 1'b0;
        end else begin
            keep_err_q <= keep_err_d;
        end
    end

    assign keep_err = keep_err_q;
`else
    assign keep_err = 1'b0;
`endif

endmodule
